// File: rtl/traffic_seq_ped.sv
// traffic_seq_ped: UK red/amber/green sequencer with a programmable dwell per
// phase, a latched pedestrian request and an all-red WALK phase.
module traffic_seq_ped #(
  parameter int TW        = 8,
  parameter int RED_CYC   = 4,
  parameter int RA_CYC    = 2,
  parameter int GREEN_CYC = 6,
  parameter int AMBER_CYC = 3,
  parameter int WALK_CYC  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ped_req,
  output logic red,
  output logic amber,
  output logic green,
  output logic walk,
  output logic ped_wait
);

  typedef enum logic [2:0] {
    S_RED   = 3'd0,
    S_RA    = 3'd1,
    S_GREEN = 3'd2,
    S_AMBER = 3'd3,
    S_WALK  = 3'd4
  } state_e;

  // Timer load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [TW-1:0] LD_RED   = TW'(RED_CYC - 1);
  localparam logic [TW-1:0] LD_RA    = TW'(RA_CYC - 1);
  localparam logic [TW-1:0] LD_GREEN = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] LD_AMBER = TW'(AMBER_CYC - 1);
  localparam logic [TW-1:0] LD_WALK  = TW'(WALK_CYC - 1);

  localparam longint MAX_CYC = longint'(1) << TW;

  // Reject dwell values the TW-bit timer cannot represent.
  if (RED_CYC < 1 || RED_CYC > MAX_CYC) begin : g_bad_red
    $error("traffic_seq_ped: RED_CYC out of range 1..2**TW");
  end
  if (RA_CYC < 1 || RA_CYC > MAX_CYC) begin : g_bad_ra
    $error("traffic_seq_ped: RA_CYC out of range 1..2**TW");
  end
  if (GREEN_CYC < 1 || GREEN_CYC > MAX_CYC) begin : g_bad_green
    $error("traffic_seq_ped: GREEN_CYC out of range 1..2**TW");
  end
  if (AMBER_CYC < 1 || AMBER_CYC > MAX_CYC) begin : g_bad_amber
    $error("traffic_seq_ped: AMBER_CYC out of range 1..2**TW");
  end
  if (WALK_CYC < 1 || WALK_CYC > MAX_CYC) begin : g_bad_walk
    $error("traffic_seq_ped: WALK_CYC out of range 1..2**TW");
  end

  function automatic logic [TW-1:0] load_of(state_e s);
    case (s)
      S_RED:   load_of = LD_RED;
      S_RA:    load_of = LD_RA;
      S_GREEN: load_of = LD_GREEN;
      S_AMBER: load_of = LD_AMBER;
      S_WALK:  load_of = LD_WALK;
      default: load_of = LD_RED;
    endcase
  endfunction

  // Lamp pattern {red, amber, green, walk} for a state.
  function automatic logic [3:0] lamps_of(state_e s);
    case (s)
      S_RED:   lamps_of = 4'b1000;
      S_RA:    lamps_of = 4'b1100;
      S_GREEN: lamps_of = 4'b0010;
      S_AMBER: lamps_of = 4'b0100;
      S_WALK:  lamps_of = 4'b1001;
      default: lamps_of = 4'b1000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ped_q, ped_d;
  logic [3:0]      lamp_q;

  // Next state: latch requests every cycle, advance the dwell only when enabled.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ped_d   = ped_q;
    if (ped_req && state_q != S_WALK) ped_d = 1'b1;
    if (en) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end else begin
        case (state_q)
          S_RED:   state_d = S_RA;
          S_RA:    state_d = S_GREEN;
          S_GREEN: state_d = S_AMBER;
          // Decision uses the latch as it stood before this edge, so a
          // request arriving on the last amber cycle waits a full round.
          S_AMBER: state_d = ped_q ? S_WALK : S_RED;
          default: state_d = S_RED;
        endcase
        timer_d = load_of(state_d);
        // Entering WALK serves the request, even one arriving this cycle.
        if (state_d == S_WALK) ped_d = 1'b0;
      end
    end
  end

  // State, timer, latch and lamps register together; lamps track state_d so
  // they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RED;
      timer_q <= LD_RED;
      ped_q   <= 1'b0;
      lamp_q  <= 4'b1000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      lamp_q  <= lamps_of(state_d);
    end
  end

  assign {red, amber, green, walk} = lamp_q;
  assign ped_wait                  = ped_q;

endmodule

// File: tb/tb_traffic_seq_ped.sv
// Directed bench for traffic_seq_ped: table-driven pedestrian round, then
// hand sequences for late requests, freeze, async reset and parameter sweep.
module tb_traffic_seq_ped;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {red, amber, green, walk, ped_wait}
  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] RA = 5'b11000;
  localparam logic [4:0] G  = 5'b00100;
  localparam logic [4:0] A  = 5'b01000;
  localparam logic [4:0] W  = 5'b10010;
  localparam logic [4:0] PW = 5'b00001;

  // Default-parameter DUT
  logic rst_n, en, ped_req;
  logic red, amber, green, walk, ped_wait;
  traffic_seq_ped u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .red(red), .amber(amber), .green(green), .walk(walk), .ped_wait(ped_wait)
  );

  // All phases one cycle long
  logic rst1_n, en1, ped1;
  logic r1, a1, g1, w1, p1;
  traffic_seq_ped #(.TW(8), .RED_CYC(1), .RA_CYC(1), .GREEN_CYC(1),
                    .AMBER_CYC(1), .WALK_CYC(1)) u_one (
    .clk(clk), .rst_n(rst1_n), .en(en1), .ped_req(ped1),
    .red(r1), .amber(a1), .green(g1), .walk(w1), .ped_wait(p1)
  );

  // Narrow timer, GREEN fills it completely
  logic rst2_n, en2, ped2;
  logic r2, a2, g2, w2, p2;
  traffic_seq_ped #(.TW(3), .GREEN_CYC(8)) u_tw3 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .ped_req(ped2),
    .red(r2), .amber(a2), .green(g2), .walk(w2), .ped_wait(p2)
  );

  typedef struct {
    logic       ped;
    logic       en;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [26];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [4:0] o0();
    return {red, amber, green, walk, ped_wait};
  endfunction
  function automatic logic [4:0] o1();
    return {r1, a1, g1, w1, p1};
  endfunction
  function automatic logic [4:0] o2();
    return {r2, a2, g2, w2, p2};
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [4:0] act,
                     input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got {r,a,g,w,pw}=%b want %b", nm, cyc, act, exp);
    end
  endtask

  // Move to the next cycle; inputs set now are sampled on the coming edge.
  task automatic next();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) next();
  endtask

  // Leaves the bench at cycle 0 (reset released, no edge taken yet).
  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; ped_req = 1'b0;
    rst1_n = 1'b0; en1 = 1'b1; ped1 = 1'b0;
    rst2_n = 1'b0; en2 = 1'b1; ped2 = 1'b0;

    // Pedestrian round: request in cycle 8 (GREEN), WALK 15-19, RED 20-23.
    for (int i = 0; i < 26; i++) begin
      tbl[i].en  = 1'b1;
      tbl[i].ped = (i == 8);
      tbl[i].exp = (i < 4)  ? R  :
                   (i < 6)  ? RA :
                   (i < 12) ? G  :
                   (i < 15) ? A  :
                   (i < 20) ? W  :
                   (i < 24) ? R  : RA;
      if (i >= 9 && i < 15) tbl[i].exp = tbl[i].exp | PW;
    end

    do_reset();
    for (int i = 0; i < 26; i++) begin
      chk("ped_round", i, o0(), tbl[i].exp);
      ped_req = tbl[i].ped;
      en      = tbl[i].en;
      next();
    end
    ped_req = 1'b0;

    // Free run, then a request on the last AMBER cycle waits one round.
    do_reset();
    steps(12);
    chk("free_amber", 12, o0(), A);
    steps(2);
    chk("last_amber", 14, o0(), A);
    ped_req = 1'b1;
    next();
    ped_req = 1'b0;
    chk("late_req_red", 15, o0(), R | PW);
    steps(4);
    chk("late_req_ra", 19, o0(), RA | PW);
    steps(8);
    chk("round2_amber", 27, o0(), A | PW);
    steps(3);
    chk("round2_walk", 30, o0(), W);
    steps(1);
    ped_req = 1'b1;              // during WALK: must be ignored
    next();
    ped_req = 1'b0;
    chk("walk_req_ign", 32, o0(), W);
    steps(3);
    chk("after_walk", 35, o0(), R);

    // Freeze mid-GREEN for 10 cycles with a request pulsed while frozen.
    do_reset();
    steps(8);
    chk("pre_freeze", 8, o0(), G);
    en = 1'b0;
    for (int k = 8; k < 18; k++) begin
      if (k == 15) chk("frozen", k, o0(), G | PW);
      ped_req = (k == 10);
      next();
    end
    ped_req = 1'b0;
    chk("freeze_end", 18, o0(), G | PW);
    en = 1'b1;
    steps(3);
    chk("green_remain", 21, o0(), G | PW);
    next();
    chk("green_done", 22, o0(), A | PW);

    // Async reset with a pending request: request discarded at once.
    do_reset();
    ped_req = 1'b1;
    next();
    ped_req = 1'b0;
    steps(2);
    chk("pending", 3, o0(), R | PW);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pending", 3, o0(), R);

    // Async reset mid-WALK, then a full RED after release.
    do_reset();
    ped_req = 1'b1;
    next();
    ped_req = 1'b0;
    steps(16);
    chk("walk_pre_rst", 17, o0(), W);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_walk", 17, o0(), R);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst", 0, o0(), R);
    steps(3);
    chk("post_rst", 3, o0(), R);
    next();
    chk("post_rst", 4, o0(), RA);

    // Parameter sweep: both variant DUTs released together.
    @(negedge clk);
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    for (int c = 0; c < 18; c++) begin
      case (c)
        0: chk("one_cyc", c, o1(), R);
        1: chk("one_cyc", c, o1(), RA);
        2: chk("one_cyc", c, o1(), G | PW);
        3: chk("one_cyc", c, o1(), A | PW);
        4: chk("one_cyc", c, o1(), W);
        5: chk("one_cyc", c, o1(), R);
        6: chk("one_cyc", c, o1(), RA);
        default: ;
      endcase
      case (c)
        3:  chk("tw3", c, o2(), R);
        4:  chk("tw3", c, o2(), RA);
        6:  chk("tw3", c, o2(), G);
        13: chk("tw3", c, o2(), G);
        14: chk("tw3", c, o2(), A);
        17: chk("tw3", c, o2(), R);
        default: ;
      endcase
      ped1 = (c == 1);
      next();
    end
    ped1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_seq_ped.md
# traffic_seq_ped

Parametrised UK traffic-light sequencer with a programmable dwell time for each phase, a latched pedestrian request and an all-red walk phase. It is the next-generation replacement for the fixed four-state light cycler: the same red/amber/green outputs, plus configurable timing, a freeze enable and pedestrian handling. It is a standalone leaf block driven by the system clock and intended for a junction top-level.

## Interface
- TW, 8: dwell timer width in bits.
- RED_CYC, 4: cycles spent in RED.
- RA_CYC, 2: cycles spent in RED_AMBER.
- GREEN_CYC, 6: cycles spent in GREEN.
- AMBER_CYC, 3: cycles spent in AMBER.
- WALK_CYC, 5: cycles spent in WALK.
- Every *_CYC value must satisfy 1 ≤ value ≤ 2^TW. A simulation-time check reports violations with $error.

- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  timer advance enable; 0 freezes the sequencer.
- ped_req  input  1  pedestrian button, single-cycle or level.
- red  output  1  red lamp.
- amber  output  1  amber lamp.
- green  output  1  green lamp.
- walk  output  1  pedestrian walk indicator.
- ped_wait  output  1  a pedestrian request is latched and not yet served.

## Operation
- States: RED, RED_AMBER, GREEN, AMBER, WALK.
- Lamp decode is Moore, taken directly from the state register:
  - RED: red=1.
  - RED_AMBER: red=1, amber=1.
  - GREEN: green=1.
  - AMBER: amber=1.
  - WALK: red=1, walk=1.
  - All other lamp outputs are 0 in each state.
- Transition order:
  - RED → RED_AMBER → GREEN → AMBER.
  - AMBER → WALK if the pedestrian latch is set, otherwise AMBER → RED.
  - WALK → RED.
- Dwell timer (TW bits, down-counter):
  - On entry to state S it loads S_CYC-1.
  - Each cycle with en=1: if timer≠0 it decrements; if timer==0 the state advances and the timer loads the next state's value.
  - With en=0, state and timer hold. ped_req is still latched while en=0.
- Pedestrian latch:
  - Set by ped_req=1 in any state except WALK. A ped_req asserted during WALK is ignored.
  - Cleared on the cycle that enters WALK. If ped_req=1 on that same cycle, the latch is still cleared, because that request is being served.
  - ped_wait equals the latch.
- Reset (rst_n=0, asynchronous):
  - state=RED, timer=RED_CYC-1, latch=0.
  - Outputs: red=1, amber=0, green=0, walk=0, ped_wait=0.
- Reset asserted mid-phase aborts the phase immediately, including WALK. Any pending request is discarded.

## Timing
- Each state is held for exactly S_CYC consecutive en=1 cycles.
- Outputs change on the clk edge at which the state changes. There is no extra output register stage.
- ped_req sampled at edge k gives ped_wait=1 after edge k.
- The AMBER→WALK decision uses the latch value before the final AMBER edge. A request on that final AMBER cycle itself therefore does not divert the sequence; it is served on the next cycle round.
- With en=1 continuously and no requests, the cycle length is RED_CYC+RA_CYC+GREEN_CYC+AMBER_CYC (15 with defaults). With a pending request, add WALK_CYC.
- The first phase after rst_n deassertion is a full RED_CYC.

## Test plan
- Reset and free run (defaults, en=1, no ped_req):
  - red for cycles 0-3, red+amber 4-5, green 6-11, amber 12-14, red again from cycle 15.
  - walk stays 0 throughout.
- Pedestrian served:
  - Pulse ped_req at cycle 8 (GREEN). Expect ped_wait=1 from cycle 9.
  - After amber ends at cycle 14: red+walk for cycles 15-19, ped_wait=0 from cycle 15, then red for cycles 20-23.
- Late request and WALK-period request:
  - ped_req on the last AMBER cycle (cycle 14): expect RED at 15 with no walk, ped_wait held, WALK served on the next cycle round.
  - ped_req during WALK: expect it ignored, ped_wait=0 after WALK.
- Freeze:
  - Drop en for 10 cycles mid-GREEN: lamps and remaining dwell unchanged.
  - A ped_req pulsed while en=0 still sets ped_wait.
  - GREEN completes its remaining cycles after en returns.
- Asynchronous reset mid-WALK:
  - Assert rst_n=0 between clock edges: red=1, walk=0, ped_wait=0 immediately.
  - After release, full RED_CYC red.
- Parameter sweep:
  - RED_CYC=RA_CYC=GREEN_CYC=AMBER_CYC=WALK_CYC=1: one cycle per state.
  - TW=3 with GREEN_CYC=8: GREEN lasts exactly 8 cycles (timer loads 7).
